// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the Y86-64 register file: serializes
// dual results onto one registered write port and tracks pending writers per register.
module regfile_wb_sched #(
  parameter int NREG = 15,
  parameter int W    = 64,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [3:0]      iss_dstE,
  input  logic [3:0]      iss_dstM,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [3:0]      wb_dstE,
  input  logic [3:0]      wb_dstM,
  input  logic [W-1:0]    wb_valE,
  input  logic [W-1:0]    wb_valM,
  output logic            wb_ready,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [W-1:0]    rf_wdata,
  input  logic [3:0]      q_srcA,
  input  logic [3:0]      q_srcB,
  output logic            hazA,
  output logic            hazB,
  output logic [NREG-1:0] busy,
  output logic            err
);

  localparam logic [3:0]    RNONE = 4'hF;
  localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_SECOND} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic            err_q, err_d;
  logic            rf_we_q, rf_we_d;
  logic [3:0]      rf_waddr_q, rf_waddr_d;
  logic [W-1:0]    rf_wdata_q, rf_wdata_d;
  logic            iss_e_v, iss_m_v, wb_e_v, wb_m_v;
  logic            iss_block, iss_fire;
  logic [NREG-1:0] hit_v, dec_v;

  function automatic logic is_real(input logic [3:0] d);
    return (d != RNONE) && (int'(d) < NREG);
  endfunction

  // E==M collapses to a single M write, so E only counts when it differs from M
  assign iss_e_v  = is_real(iss_dstE) && (iss_dstE != iss_dstM);
  assign iss_m_v  = is_real(iss_dstM);
  assign wb_e_v   = is_real(wb_dstE) && (wb_dstE != wb_dstM);
  assign wb_m_v   = is_real(wb_dstM);

  assign iss_ready = rst_n && !iss_block;
  assign iss_fire  = iss_valid && iss_ready;

  always_comb begin
    iss_block = 1'b0;
    hazA      = 1'b0;
    hazB      = 1'b0;
    busy      = '0;
    hit_v     = '0;
    dec_v     = '0;
    for (int i = 0; i < NREG; i++) begin
      busy[i]  = (cnt_q[i] != '0);
      hit_v[i] = (iss_e_v && (iss_dstE == 4'(i))) || (iss_m_v && (iss_dstM == 4'(i)));
      dec_v[i] = rf_we_q && (rf_waddr_q == 4'(i));
      if (hit_v[i] && (cnt_q[i] == CMAX) && !dec_v[i]) iss_block = 1'b1;
      if (q_srcA == 4'(i)) hazA = busy[i];
      if (q_srcB == 4'(i)) hazB = busy[i];
    end
  end

  // Underflowing commits are dropped from the count but flagged
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dec_v[i] && (cnt_q[i] == '0)) begin
        err_d = 1'b1;
        if (iss_fire && hit_v[i]) cnt_d[i] = cnt_q[i] + CONE;
      end else if (iss_fire && hit_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CONE;
      end else if (dec_v[i] && !(iss_fire && hit_v[i])) begin
        cnt_d[i] = cnt_q[i] - CONE;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_ready   = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = RNONE;
    rf_wdata_d = '0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          wb_ready = 1'b1;
          if (wb_valid) begin
            if (wb_e_v && wb_m_v) begin
              wb_ready   = 1'b0;
              rf_we_d    = 1'b1;
              rf_waddr_d = wb_dstE;
              rf_wdata_d = wb_valE;
              state_d    = S_SECOND;
            end else if (wb_m_v) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = wb_dstM;
              rf_wdata_d = wb_valM;
            end else if (wb_e_v) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = wb_dstE;
              rf_wdata_d = wb_valE;
            end
          end
        end
        S_SECOND: begin
          wb_ready   = 1'b1;
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_dstM;
          rf_wdata_d = wb_valM;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= RNONE;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign err      = err_q;

endmodule
